// File: rtl/result_packet_gather_pkg.sv
// result_packet_gather_pkg
// Shared definitions for the result packet gather block: derived size
// functions, the gather state enum and the commit header struct used on
// both the input and output sides.
package result_packet_gather_pkg;

  // Default header field widths; the header struct is built from these.
  localparam int DEF_UUID_W = 44;
  localparam int DEF_NW_W   = 2;
  localparam int DEF_PC_W   = 30;
  localparam int DEF_NR_W   = 6;

  // Number of lane packets that make up one warp.
  function automatic int num_packets(input int nt, input int nl);
    return nt / nl;
  endfunction

  // Packet index width; a single-packet warp still carries a 1-bit pid.
  function automatic int pid_w(input int nt, input int nl);
    int np;
    np = nt / nl;
    return (np > 1) ? $clog2(np) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no partial warp
    ST_ACCUM = 2'd1,  // sop seen, waiting for eop
    ST_FULL  = 2'd2   // complete record held for output
  } state_t;

  typedef struct packed {
    logic [DEF_UUID_W-1:0] uuid;
    logic [DEF_NW_W-1:0]   wid;
    logic [DEF_PC_W-1:0]   pc;
    logic                  wb;
    logic [DEF_NR_W-1:0]   rd;
  } hdr_t;

endpackage

// File: rtl/result_packet_gather_slot_merge.sv
// gather_slot_merge
// Combinational slice writer. Optionally clears the accumulated thread mask
// and data, then overwrites the slice selected by i_pid with the packet's
// lane mask and lane data. All other slices pass through unchanged.
// Ports:
//   i_tmask/i_data        current accumulated mask / data
//   i_pid                 packet index selecting the slice
//   i_pkt_tmask/i_pkt_data packet lane mask / data (lane 0 in LSBs)
//   i_clear               zero everything before the slice write
//   o_tmask/o_data        next accumulated mask / data
module gather_slot_merge
  import result_packet_gather_pkg::*;
#(
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int PID_W       = 2
) (
  input  logic [NUM_THREADS-1:0]      i_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] i_data,
  input  logic [PID_W-1:0]            i_pid,
  input  logic [NUM_LANES-1:0]        i_pkt_tmask,
  input  logic [NUM_LANES*XLEN-1:0]   i_pkt_data,
  input  logic                        i_clear,
  output logic [NUM_THREADS-1:0]      o_tmask,
  output logic [NUM_THREADS*XLEN-1:0] o_data
);

  localparam int NUM_PACKETS = num_packets(NUM_THREADS, NUM_LANES);

  always_comb begin
    o_tmask = i_clear ? '0 : i_tmask;
    o_data  = i_clear ? '0 : i_data;
    // Constant-indexed slices: one comparator per slot rather than a
    // variable part-select.
    for (int p = 0; p < NUM_PACKETS; p++) begin
      if (i_pid == PID_W'(p)) begin
        o_tmask[p*NUM_LANES +: NUM_LANES]          = i_pkt_tmask;
        o_data[p*NUM_LANES*XLEN +: NUM_LANES*XLEN] = i_pkt_data;
      end
    end
  end

endmodule

// File: rtl/result_packet_gather.sv
// result_packet_gather
// Reassembles lane-sliced result packets (pid/sop/eop framed) into one
// full-warp commit record of NUM_THREADS lanes, held until downstream takes it.
// Optional build macro: GATHER_CHECK_EN enables the sticky framing error
// detector driving gather_err; without it gather_err is tied low.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_*                  input packet: header, lane mask/data, pid, sop, eop
//   in_valid/in_ready     input handshake
//   out_*                 commit record: latched header, merged mask/data
//   out_valid/out_ready   output handshake
//   gather_err            sticky framing error
//   o_dbg_state           current gather state (state_t encoding)
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high; valid never waits on ready, and ready may depend on the far side's
// ready only (out_ready -> in_ready is the sole combinational path).
module result_packet_gather
  import result_packet_gather_pkg::*;
#(
  parameter  int NUM_THREADS = 8,
  parameter  int NUM_LANES   = 2,
  parameter  int XLEN        = 32,
  parameter  int UUID_W      = DEF_UUID_W,
  parameter  int NW_W        = DEF_NW_W,
  parameter  int PC_W        = DEF_PC_W,
  parameter  int NR_W        = DEF_NR_W,
  localparam int PID_W       = pid_w(NUM_THREADS, NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UUID_W-1:0]           in_uuid,
  input  logic [NW_W-1:0]             in_wid,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [PC_W-1:0]             in_pc,
  input  logic                        in_wb,
  input  logic [NR_W-1:0]             in_rd,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [PID_W-1:0]            in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UUID_W-1:0]           out_uuid,
  output logic [NW_W-1:0]             out_wid,
  output logic [PC_W-1:0]             out_pc,
  output logic                        out_wb,
  output logic [NR_W-1:0]             out_rd,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic                        gather_err,
  output logic [1:0]                  o_dbg_state
);

  localparam int NUM_PACKETS = num_packets(NUM_THREADS, NUM_LANES);
  localparam bit SINGLE_PKT  = (NUM_PACKETS == 1);

  state_t                      r_state;
  hdr_t                        r_hdr;
  logic [NUM_THREADS-1:0]      r_tmask;
  logic [NUM_THREADS*XLEN-1:0] r_data;

  logic                        w_fire;
  logic                        w_sop;
  logic                        w_eop;
  logic [PID_W-1:0]            w_pid;
  logic [NUM_THREADS-1:0]      w_next_tmask;
  logic [NUM_THREADS*XLEN-1:0] w_next_data;

  // A held record blocks input unless it is drained in the same cycle.
  assign in_ready = (r_state != ST_FULL) || out_ready;
  assign w_fire   = in_valid && in_ready;

  // When a warp fits in one packet, every packet is a whole instruction.
  assign w_sop = SINGLE_PKT ? 1'b1 : in_sop;
  assign w_eop = SINGLE_PKT ? 1'b1 : in_eop;
  assign w_pid = SINGLE_PKT ? '0 : in_pid;

  gather_slot_merge #(
    .NUM_THREADS (NUM_THREADS),
    .NUM_LANES   (NUM_LANES),
    .XLEN        (XLEN),
    .PID_W       (PID_W)
  ) u_merge (
    .i_tmask     (r_tmask),
    .i_data      (r_data),
    .i_pid       (w_pid),
    .i_pkt_tmask (in_tmask),
    .i_pkt_data  (in_data),
    .i_clear     (w_sop),
    .o_tmask     (w_next_tmask),
    .o_data      (w_next_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_hdr   <= '0;
      r_tmask <= '0;
      r_data  <= '0;
    end else if (w_fire) begin
      // A fire while FULL implies out_ready, so the old record is consumed
      // and the state simply follows the new packet.
      r_tmask <= w_next_tmask;
      r_data  <= w_next_data;
      if (w_sop) begin
        r_hdr.uuid <= in_uuid;
        r_hdr.wid  <= in_wid;
        r_hdr.pc   <= in_pc;
        r_hdr.wb   <= in_wb;
        r_hdr.rd   <= in_rd;
      end
      r_state <= w_eop ? ST_FULL : ST_ACCUM;
    end else if (r_state == ST_FULL && out_ready) begin
      r_state <= ST_IDLE;
    end
  end

  assign out_valid   = (r_state == ST_FULL);
  assign out_uuid    = r_hdr.uuid;
  assign out_wid     = r_hdr.wid;
  assign out_pc      = r_hdr.pc;
  assign out_wb      = r_hdr.wb;
  assign out_rd      = r_hdr.rd;
  assign out_tmask   = r_tmask;
  assign out_data    = r_data;
  assign o_dbg_state = r_state;

`ifdef GATHER_CHECK_EN
  logic [NUM_PACKETS-1:0] r_written;
  logic                   r_err;
  logic [NUM_PACKETS-1:0] w_pid_onehot;
  logic                   w_err_now;

  always_comb begin
    w_pid_onehot = '0;
    for (int p = 0; p < NUM_PACKETS; p++) begin
      if (w_pid == PID_W'(p)) w_pid_onehot[p] = 1'b1;
    end
    w_err_now = 1'b0;
    if (w_fire) begin
      if (!w_sop && r_state == ST_IDLE) w_err_now = 1'b1;
      if (w_sop && r_state == ST_ACCUM) w_err_now = 1'b1;
      if (!w_sop && (in_wid != r_hdr.wid || in_uuid != r_hdr.uuid)) w_err_now = 1'b1;
      // A sop restarts the slot map, so only continuation packets can collide.
      if (!w_sop && |(r_written & w_pid_onehot)) w_err_now = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_written <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_err_now) r_err <= 1'b1;
      if (w_fire) r_written <= w_sop ? w_pid_onehot : (r_written | w_pid_onehot);
    end
  end

  assign gather_err = r_err;
`else
  assign gather_err = 1'b0;
`endif

endmodule

// File: tb/tb_result_packet_gather.sv
`timescale 1ns/1ps
module tb_result_packet_gather;

  localparam int NT   = 8;
  localparam int NL   = 2;
  localparam int NP   = 4;
  localparam int XLEN = 32;
`ifdef GATHER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- 8-thread / 2-lane DUT ----------------
  logic           in_valid, in_ready, in_wb, in_sop, in_eop;
  logic [43:0]    in_uuid;
  logic [1:0]     in_wid, in_tmask, in_pid;
  logic [29:0]    in_pc;
  logic [5:0]     in_rd;
  logic [63:0]    in_data;
  logic           out_valid, out_ready, out_wb, gather_err;
  logic [43:0]    out_uuid;
  logic [1:0]     out_wid, dbg_state;
  logic [29:0]    out_pc;
  logic [5:0]     out_rd;
  logic [7:0]     out_tmask;
  logic [255:0]   out_data;

  result_packet_gather #(.NUM_THREADS(8), .NUM_LANES(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid), .in_wid(in_wid),
    .in_tmask(in_tmask), .in_pc(in_pc), .in_wb(in_wb), .in_rd(in_rd),
    .in_data(in_data), .in_pid(in_pid), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid),
    .out_wid(out_wid), .out_pc(out_pc), .out_wb(out_wb), .out_rd(out_rd),
    .out_tmask(out_tmask), .out_data(out_data), .gather_err(gather_err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- 4-thread / 4-lane DUT ----------------
  logic           b_in_valid, b_in_ready, b_in_wb, b_in_sop, b_in_eop;
  logic [43:0]    b_in_uuid;
  logic [1:0]     b_in_wid;
  logic [3:0]     b_in_tmask;
  logic [0:0]     b_in_pid;
  logic [29:0]    b_in_pc;
  logic [5:0]     b_in_rd;
  logic [127:0]   b_in_data;
  logic           b_out_valid, b_out_ready, b_out_wb, b_gather_err;
  logic [43:0]    b_out_uuid;
  logic [1:0]     b_out_wid, b_dbg_state;
  logic [29:0]    b_out_pc;
  logic [5:0]     b_out_rd;
  logic [3:0]     b_out_tmask;
  logic [127:0]   b_out_data;

  result_packet_gather #(.NUM_THREADS(4), .NUM_LANES(4)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_uuid(b_in_uuid), .in_wid(b_in_wid),
    .in_tmask(b_in_tmask), .in_pc(b_in_pc), .in_wb(b_in_wb), .in_rd(b_in_rd),
    .in_data(b_in_data), .in_pid(b_in_pid), .in_sop(b_in_sop), .in_eop(b_in_eop),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_uuid(b_out_uuid),
    .out_wid(b_out_wid), .out_pc(b_out_pc), .out_wb(b_out_wb), .out_rd(b_out_rd),
    .out_tmask(b_out_tmask), .out_data(b_out_data), .gather_err(b_gather_err),
    .o_dbg_state(b_dbg_state)
  );

  // ---------------- check helpers ----------------
  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_v(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model (8-thread DUT) ----------------
  // Tracks the warp as per-thread mask/data arrays plus a "record pending"
  // flag and an "instruction open" flag.
  logic        m_pending, m_open, m_err;
  logic        m_mask   [NT];
  logic [31:0] m_tdata  [NT];
  logic        m_written[NP];
  logic [43:0] m_uuid;
  logic [1:0]  m_wid;
  logic [29:0] m_pc;
  logic        m_wb;
  logic [5:0]  m_rd;

  always @(posedge clk) begin : model
    logic fire, prev_pending, prev_open, bad;
    if (reset) begin
      m_pending = 1'b0; m_open = 1'b0; m_err = 1'b0;
      for (int t = 0; t < NT; t++) begin m_mask[t] = 1'b0; m_tdata[t] = '0; end
      for (int p = 0; p < NP; p++) m_written[p] = 1'b0;
      m_uuid = '0; m_wid = '0; m_pc = '0; m_wb = 1'b0; m_rd = '0;
    end else begin
      prev_pending = m_pending;
      prev_open    = m_open;
      fire = in_valid && (!m_pending || out_ready);
      if (m_pending && out_ready) m_pending = 1'b0;
      if (fire) begin
        bad = 1'b0;
        if (!in_sop && !prev_open && !prev_pending) bad = 1'b1;
        if (in_sop && prev_open) bad = 1'b1;
        if (!in_sop && (in_wid != m_wid || in_uuid != m_uuid)) bad = 1'b1;
        if (!in_sop && m_written[in_pid]) bad = 1'b1;
        m_err = m_err | (bad & CHECK_EN);
        if (in_sop) begin
          for (int t = 0; t < NT; t++) begin m_mask[t] = 1'b0; m_tdata[t] = '0; end
          for (int p = 0; p < NP; p++) m_written[p] = 1'b0;
          m_uuid = in_uuid; m_wid = in_wid; m_pc = in_pc; m_wb = in_wb; m_rd = in_rd;
        end
        for (int l = 0; l < NL; l++) begin
          m_mask[int'(in_pid) * NL + l]  = in_tmask[l];
          m_tdata[int'(in_pid) * NL + l] = in_data[l*XLEN +: XLEN];
        end
        m_written[in_pid] = 1'b1;
        if (in_eop) begin m_pending = 1'b1; m_open = 1'b0; end
        else m_open = 1'b1;
      end
    end
  end

  // Single compare process: every cycle out of reset.
  always @(negedge clk) begin : compare
    logic [7:0]   exp_mask;
    logic [255:0] exp_data;
    if (!reset) begin
      check_b("model out_valid", out_valid, m_pending);
      check_b("model in_ready", in_ready, !m_pending || out_ready);
      check_b("model gather_err", gather_err, m_err);
      if (m_pending) begin
        for (int t = 0; t < NT; t++) begin
          exp_mask[t] = m_mask[t];
          exp_data[t*XLEN +: XLEN] = m_tdata[t];
        end
        check_v("model out_tmask", 256'(out_tmask), 256'(exp_mask));
        check_v("model out_data", out_data, exp_data);
        check_v("model out_uuid", 256'(out_uuid), 256'(m_uuid));
        check_v("model out_wid", 256'(out_wid), 256'(m_wid));
        check_v("model out_pc", 256'(out_pc), 256'(m_pc));
        check_b("model out_wb", out_wb, m_wb);
        check_v("model out_rd", 256'(out_rd), 256'(m_rd));
      end
    end
  end

  // ---------------- drivers ----------------
  logic rand_ordy = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Presents one packet to the 8-thread DUT and holds it until accepted.
  // Entered and left at 1ns after a rising edge.
  task automatic send8(input logic sop, input logic eop, input logic [1:0] pid,
                       input logic [1:0] tm, input logic [63:0] d,
                       input logic [43:0] uuid, input logic [1:0] wid,
                       input logic [29:0] pc, input logic wb, input logic [5:0] rd);
    logic fired;
    fired = 1'b0;
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_pid = pid; in_tmask = tm;
    in_data = d; in_uuid = uuid; in_wid = wid; in_pc = pc; in_wb = wb; in_rd = rd;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin fired = 1'b1; break; end
      tick();
    end
    if (!fired) begin
      checks++; errors++;
      $display("FAIL send8 timeout actual=in_ready_low required=accept");
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  logic [131:0] exp_q[$];

  task automatic drive4();
    b_in_valid = 1'b1;
    b_in_tmask = 4'($urandom_range(0, 15));
    b_in_data  = {$urandom, $urandom, $urandom, $urandom};
    b_in_pid   = 1'($urandom_range(0, 1));
    b_in_sop   = 1'($urandom_range(0, 1));
    b_in_eop   = 1'($urandom_range(0, 1));
    b_in_uuid  = {12'h0, $urandom};
    exp_q.push_back({b_in_tmask, b_in_data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [131:0] e;
    logic [1:0]   first_p, last_p;
    logic [3:0]   pmask;
    logic [43:0]  uu;
    logic [1:0]   wd;
    logic [29:0]  pc;
    logic [5:0]   rd;
    logic         wb;

    in_valid = 0; in_sop = 0; in_eop = 0; in_pid = 0; in_tmask = 0; in_data = 0;
    in_uuid = 0; in_wid = 0; in_pc = 0; in_wb = 0; in_rd = 0; out_ready = 0;
    b_in_valid = 0; b_in_sop = 0; b_in_eop = 0; b_in_pid = 0; b_in_tmask = 0;
    b_in_data = 0; b_in_uuid = 0; b_in_wid = 0; b_in_pc = 0; b_in_wb = 0; b_in_rd = 0;
    b_out_ready = 0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values.
    check_b("rst out_valid", out_valid, 1'b0);
    check_v("rst out_tmask", 256'(out_tmask), 256'h0);
    check_v("rst out_data", out_data, 256'h0);
    check_v("rst out_uuid", 256'(out_uuid), 256'h0);
    check_v("rst out_pc", 256'(out_pc), 256'h0);
    check_b("rst in_ready", in_ready, 1'b1);
    check_b("rst gather_err", gather_err, 1'b0);
    check_b("rst b out_valid", b_out_valid, 1'b0);
    check_v("rst b out_tmask", 256'(b_out_tmask), 256'h0);

    // Full warp, data = thread index.
    for (int p = 0; p < 4; p++)
      send8(p == 0, p == 3, 2'(p), 2'b11, {32'(2*p+1), 32'(2*p)}, 44'h123, 2'd1, 30'h55, 1'b1, 6'd5);
    check_b("full out_valid", out_valid, 1'b1);
    check_v("full out_tmask", 256'(out_tmask), 256'hFF);
    check_v("full out_data", out_data,
            256'h0000000700000006000000050000000400000003000000020000000100000000);
    check_v("full out_uuid", 256'(out_uuid), 256'h123);

    // Backpressure: record held, next sop waiting.
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_pid = 2'd1; in_tmask = 2'b01;
    in_data = {32'hB, 32'hA}; in_uuid = 44'h77; in_wid = 2'd2; in_pc = 30'h9; in_wb = 1'b0; in_rd = 6'd3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_b("bp in_ready", in_ready, 1'b0);
      check_b("bp out_valid", out_valid, 1'b1);
      check_v("bp out_tmask", 256'(out_tmask), 256'hFF);
      check_v("bp out_data", out_data,
              256'h0000000700000006000000050000000400000003000000020000000100000000);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_b("bp release in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check_b("bp consumed out_valid", out_valid, 1'b0);

    // Sparse warp completion: pid1 (lane0) + pid3 (lane1).
    send8(1'b0, 1'b1, 2'd3, 2'b10, {32'hD, 32'hC}, 44'h77, 2'd2, 30'h0, 1'b0, 6'd0);
    check_v("sparse out_tmask", 256'(out_tmask), 256'h84);
    check_v("sparse out_data", out_data,
            256'h0000000D0000000C00000000000000000000000B0000000A0000000000000000);
    check_v("sparse out_wid", 256'(out_wid), 256'h2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a 4-packet warp.
    send8(1'b1, 1'b0, 2'd0, 2'b11, {32'h1, 32'h2}, 44'h9, 2'd0, 30'h1, 1'b1, 6'd1);
    send8(1'b0, 1'b0, 2'd1, 2'b11, {32'h3, 32'h4}, 44'h9, 2'd0, 30'h1, 1'b1, 6'd1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_b("mid-rst out_valid", out_valid, 1'b0);
    check_v("mid-rst out_tmask", 256'(out_tmask), 256'h0);
    check_b("mid-rst in_ready", in_ready, 1'b1);
    for (int p = 0; p < 4; p++)
      send8(p == 0, p == 3, 2'(p), 2'b11, {32'(2*p+17), 32'(2*p+16)}, 44'hABC, 2'd3, 30'h7, 1'b1, 6'd9);
    check_v("post-rst out_tmask", 256'(out_tmask), 256'hFF);
    check_v("post-rst out_data", out_data,
            256'h0000001700000016000000150000001400000013000000120000001100000010);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Single-packet warp DUT: one record per cycle, pid/sop/eop ignored.
    b_out_ready = 1'b1;
    drive4();
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_b("b in_ready", b_in_ready, 1'b1);
      check_b("b out_valid", b_out_valid, 1'b1);
      e = exp_q.pop_front();
      check_v("b out_tmask", 256'(b_out_tmask), 256'(e[131:128]));
      check_v("b out_data", 256'(b_out_data), 256'(e[127:0]));
      if (k < 6) drive4();
      else b_in_valid = 1'b0;
    end
    tick();
    check_b("b drained out_valid", b_out_valid, 1'b0);
    check_b("b gather_err", b_gather_err, 1'b0);

    // Randomized well-formed warps with random backpressure.
    rand_ordy = 1'b1;
    for (int w = 0; w < 60; w++) begin
      pmask = 4'($urandom_range(1, 15));
      first_p = 0; last_p = 0;
      for (int p = 3; p >= 0; p--) if (pmask[p]) first_p = 2'(p);
      for (int p = 0; p < 4; p++) if (pmask[p]) last_p = 2'(p);
      uu = {12'($urandom), $urandom};
      wd = 2'($urandom_range(0, 3));
      pc = 30'($urandom);
      rd = 6'($urandom_range(0, 63));
      wb = 1'($urandom_range(0, 1));
      for (int p = 0; p < 4; p++) begin
        if (pmask[p]) begin
          send8(2'(p) == first_p, 2'(p) == last_p, 2'(p), 2'($urandom_range(0, 3)),
                {$urandom, $urandom}, uu, wd, pc, wb, rd);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
    end
    rand_ordy = 1'b0;
    #0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Framing error: continuation packet while idle.
    send8(1'b0, 1'b0, 2'd2, 2'b01, 64'h5, 44'h0, 2'd0, 30'h0, 1'b0, 6'd0);
    check_b("err set", gather_err, CHECK_EN);
    repeat (3) tick();
    check_b("err sticky", gather_err, CHECK_EN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
